// File: rtl/sudoku_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sudoku_pkg : shared types, constants and cell helpers for the board  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package sudoku_pkg;

  localparam int NUM_CELLS = 81;
  localparam int CELL_W    = 4;
  localparam int IDX_W     = 7;
  localparam logic [3:0] ROW_OFFGRID = 4'd15;

  typedef enum logic [0:0] {S_LOCK, S_PLAY} state_t;
  typedef enum logic [1:0] {SRC_UNDO, SRC_REC, SRC_CLR, SRC_PUT} src_t;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return IDX_W'(row) * IDX_W'(9) + IDX_W'(col);
  endfunction

  function automatic logic in_grid(input logic [3:0] row, input logic [3:0] col);
    return (row != ROW_OFFGRID) && (col != ROW_OFFGRID) && (row < 4'd9) && (col < 4'd9);
  endfunction

  function automatic logic [3:0] idx_row(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] q;
    q = idx / IDX_W'(9);
    return q[3:0];
  endfunction

  function automatic logic [3:0] idx_col(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = idx % IDX_W'(9);
    return r[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sudoku_move_ctrl_undo_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sudoku_undo_stack : circular LIFO of {idx, old value} move records   |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module sudoku_undo_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           top_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;

  // ptr wraps freely; once full the oldest slot is the next one overwritten
  assign top_data = mem[ptr - PW'(1)];
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != (PW+1)'(DEPTH)) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sudoku_move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sudoku_move_ctrl : arbitrated, validated single-port board writer    |
// | Optional undo history built when SUDOKU_MOVE_UNDO_EN is defined.     |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module sudoku_move_ctrl
  import sudoku_pkg::*;
#(
  parameter int UNDO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        game_active,
  input  logic [NUM_CELLS*CELL_W-1:0] board,
  input  logic [NUM_CELLS-1:0]        board_blank,
  input  logic                        rec_req,
  input  logic [3:0]                  rec_row,
  input  logic [3:0]                  rec_col,
  input  logic [3:0]                  rec_data,
  output logic                        rec_ack,
  input  logic [3:0]                  mouse_row,
  input  logic [3:0]                  mouse_col,
  input  logic                        MOUSE_MIDDLE,
  input  logic                        MOUSE_RIGHT,
  input  logic                        undo_req,
  output logic                        wr_en,
  output logic [3:0]                  wr_row,
  output logic [3:0]                  wr_col,
  output logic [3:0]                  wr_data,
  output logic [3:0]                  pen_data,
  output logic                        reject,
  output logic [CNT_W-1:0]            move_count
);

  localparam int HW = IDX_W + CELL_W;

  state_t state, state_next;

  logic       mid_d, right_d, mid_rel, right_rel;
  logic       clr_pend, put_pend;
  logic [3:0] clr_row, clr_col, put_row, put_col;

  logic             rec_go, undo_go, rec_digit_ok;
  src_t             sel;
  logic             sel_vld;
  logic [3:0]       cand_row, cand_col, cand_data;
  logic             data_ok, in_bnd, cand_ok;
  logic [IDX_W-1:0] cand_idx;
  logic [3:0]       board_val, old_val;

  logic          hist_empty;
  logic [HW-1:0] hist_top;

  logic       game_start, push, pop, clr_served, put_served, cnt_inc;
  logic       nx_wr_en, nx_ack, nx_reject;
  logic [3:0] nx_row, nx_col, nx_data, nx_pen;

  assign mid_rel      = mid_d & ~MOUSE_MIDDLE;
  assign right_rel    = right_d & ~MOUSE_RIGHT;
  // requester holds rec_req through the ack cycle, so that cycle is not a new request
  assign rec_go       = rec_req & ~rec_ack;
  assign rec_digit_ok = (rec_data >= 4'd1) && (rec_data <= 4'd9);

  always_comb begin
    sel       = SRC_PUT;
    sel_vld   = 1'b1;
    if (undo_go)       sel = SRC_UNDO;
    else if (rec_go)   sel = SRC_REC;
    else if (clr_pend) sel = SRC_CLR;
    else if (put_pend) sel = SRC_PUT;
    else               sel_vld = 1'b0;

    cand_row  = put_row;
    cand_col  = put_col;
    cand_data = pen_data;
    data_ok   = (pen_data != 4'd0);
    case (sel)
      SRC_REC: begin
        cand_row  = rec_row;
        cand_col  = rec_col;
        cand_data = rec_data;
        data_ok   = rec_digit_ok;
      end
      SRC_CLR: begin
        cand_row  = clr_row;
        cand_col  = clr_col;
        cand_data = 4'd0;
        data_ok   = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_bnd    = in_grid(cand_row, cand_col);
  assign cand_idx  = in_bnd ? cell_idx(cand_row, cand_col) : '0;
  assign board_val = board[cand_idx*CELL_W +: CELL_W];
  // the board register lags our strobe by a cycle, so a write in flight holds the true value
  assign old_val   = (wr_en && wr_row == cand_row && wr_col == cand_col) ? wr_data : board_val;
  assign cand_ok   = in_bnd && board_blank[cand_idx] && data_ok;

  always_comb begin
    state_next = state;
    game_start = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    clr_served = 1'b0;
    put_served = 1'b0;
    cnt_inc    = 1'b0;
    nx_wr_en   = 1'b0;
    nx_ack     = 1'b0;
    nx_reject  = 1'b0;
    nx_row     = wr_row;
    nx_col     = wr_col;
    nx_data    = wr_data;
    nx_pen     = pen_data;
    case (state)
      S_LOCK: begin
        if (game_active) begin
          state_next = S_PLAY;
          game_start = 1'b1;
        end
        if (rec_go) begin
          nx_ack    = 1'b1;
          nx_reject = 1'b1;
          if (rec_digit_ok) nx_pen = rec_data;
        end
      end
      S_PLAY: begin
        if (!game_active) state_next = S_LOCK;
        if (sel_vld) begin
          if (sel == SRC_UNDO) begin
            if (hist_empty) begin
              nx_reject = 1'b1;
            end else begin
              pop      = 1'b1;
              nx_wr_en = 1'b1;
              nx_row   = idx_row(hist_top[HW-1 -: IDX_W]);
              nx_col   = idx_col(hist_top[HW-1 -: IDX_W]);
              nx_data  = hist_top[CELL_W-1:0];
            end
          end else begin
            if (sel == SRC_REC) begin
              nx_ack = 1'b1;
              if (rec_digit_ok) nx_pen = rec_data;
            end
            clr_served = (sel == SRC_CLR);
            put_served = (sel == SRC_PUT);
            if (cand_ok) begin
              nx_wr_en = 1'b1;
              nx_row   = cand_row;
              nx_col   = cand_col;
              nx_data  = cand_data;
              cnt_inc  = 1'b1;
              push     = (cand_data != old_val);
            end else begin
              nx_reject = 1'b1;
            end
          end
        end
      end
      default: state_next = S_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOCK;
      mid_d      <= 1'b0;
      right_d    <= 1'b0;
      clr_pend   <= 1'b0;
      put_pend   <= 1'b0;
      clr_row    <= '0;
      clr_col    <= '0;
      put_row    <= '0;
      put_col    <= '0;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= '0;
      rec_ack    <= 1'b0;
      reject     <= 1'b0;
      pen_data   <= '0;
      move_count <= '0;
    end else begin
      state    <= state_next;
      mid_d    <= MOUSE_MIDDLE;
      right_d  <= MOUSE_RIGHT;
      wr_en    <= nx_wr_en;
      wr_row   <= nx_row;
      wr_col   <= nx_col;
      wr_data  <= nx_data;
      rec_ack  <= nx_ack;
      reject   <= nx_reject;
      pen_data <= nx_pen;

      if (state != S_PLAY || !game_active) begin
        clr_pend <= 1'b0;
        put_pend <= 1'b0;
      end else begin
        // a fresh release replaces whatever was in the slot, served or not
        if (mid_rel) begin
          clr_pend <= 1'b1;
          clr_row  <= mouse_row;
          clr_col  <= mouse_col;
        end else if (clr_served) begin
          clr_pend <= 1'b0;
        end
        if (right_rel) begin
          put_pend <= 1'b1;
          put_row  <= mouse_row;
          put_col  <= mouse_col;
        end else if (put_served) begin
          put_pend <= 1'b0;
        end
      end

      if (game_start)
        move_count <= '0;
      else if (cnt_inc && move_count != {CNT_W{1'b1}})
        move_count <= move_count + CNT_W'(1);
    end
  end

`ifdef SUDOKU_MOVE_UNDO_EN
  logic [$clog2(UNDO_DEPTH):0] hist_count;
  logic                        unused_hist;

  assign undo_go     = undo_req && (state == S_PLAY);
  assign unused_hist = ^hist_count;

  sudoku_undo_stack #(
    .DEPTH (UNDO_DEPTH),
    .W     (HW)
  ) u_undo (
    .clk       (clk),
    .reset     (reset),
    .clear     (game_start),
    .push      (push),
    .push_data ({cand_idx, old_val}),
    .pop       (pop),
    .top_data  (hist_top),
    .empty     (hist_empty),
    .count     (hist_count)
  );
`else
  localparam int unused_depth = UNDO_DEPTH;
  logic unused_undo;

  assign undo_go     = 1'b0;
  assign hist_empty  = 1'b1;
  assign hist_top    = '0;
  assign unused_undo = ^{undo_req, push, pop, old_val};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sudoku_move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sudoku_move_ctrl : directed scoreboard bench for sudoku_move_ctrl |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_sudoku_move_ctrl;

  localparam int UNDO_DEPTH = 16;
  localparam int CNT_W      = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          game_active = 1'b0;
  logic [323:0]  board;
  logic [80:0]   board_blank;
  logic          rec_req = 1'b0;
  logic [3:0]    rec_row = '0, rec_col = '0, rec_data = '0;
  logic          rec_ack;
  logic [3:0]    mouse_row = '0, mouse_col = '0;
  logic          MOUSE_MIDDLE = 1'b0, MOUSE_RIGHT = 1'b0;
  logic          undo_req = 1'b0;
  logic          wr_en;
  logic [3:0]    wr_row, wr_col, wr_data, pen_data;
  logic          reject;
  logic [CNT_W-1:0] move_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic       we;
    logic [3:0] row, col, data;
    logic       ack, rej;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  sudoku_move_ctrl #(.UNDO_DEPTH(UNDO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .game_active(game_active), .board(board),
    .board_blank(board_blank), .rec_req(rec_req), .rec_row(rec_row),
    .rec_col(rec_col), .rec_data(rec_data), .rec_ack(rec_ack),
    .mouse_row(mouse_row), .mouse_col(mouse_col), .MOUSE_MIDDLE(MOUSE_MIDDLE),
    .MOUSE_RIGHT(MOUSE_RIGHT), .undo_req(undo_req), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .pen_data(pen_data),
    .reject(reject), .move_count(move_count)
  );

  always #5 clk = ~clk;

  initial board_blank = {80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0};

  // board register: cell (0,0) is a fixed clue 5, everything else starts empty
  always @(posedge clk) begin
    if (reset) board <= {320'd0, 4'd5};
    else if (wr_en) board[(int'(wr_row)*9 + int'(wr_col))*4 +: 4] <= wr_data;
  end

  always @(negedge clk) begin
    if (!reset && (wr_en || rec_ack || reject)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out we=%0d ack=%0d rej=%0d expected no output", wr_en, rec_ack, reject);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert ({wr_en, rec_ack, reject} === {e.we, e.ack, e.rej}) else begin
          errors++;
          $error("FAIL strobes_%0d got we/ack/rej=%b expected %b", e.id, {wr_en, rec_ack, reject}, {e.we, e.ack, e.rej});
        end
        if (e.we) begin
          checks++;
          assert ({wr_row, wr_col, wr_data} === {e.row, e.col, e.data}) else begin
            errors++;
            $error("FAIL write_%0d got r/c/d=%h expected %h", e.id, {wr_row, wr_col, wr_data}, {e.row, e.col, e.data});
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input int id, input logic we, input logic [3:0] r, input logic [3:0] c,
                         input logic [3:0] d, input logic a, input logic rj);
    exp_t x;
    x.id = id; x.we = we; x.row = r; x.col = c; x.data = d; x.ack = a; x.rej = rj;
    sb.push_back(x);
  endtask

  task automatic rec(input logic [3:0] r, input logic [3:0] c, input logic [3:0] d);
    logic acked;
    acked = 1'b0;
    rec_row = r; rec_col = c; rec_data = d; rec_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rec_ack) begin
        acked = 1'b1;
        break;
      end
    end
    rec_req = 1'b0;
    checks++;
    assert (acked === 1'b1) else begin
      errors++;
      $error("FAIL rec_ack_timeout got %b expected 1", acked);
    end
  endtask

  task automatic drain(input int id);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_%0d pending=%0d expected 0", id, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_val(input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL value_%0d got %0d expected %0d", id, got, want);
    end
  endtask

  task automatic release_btn(input logic right, input logic [3:0] r, input logic [3:0] c);
    mouse_row = r; mouse_col = c;
    if (right) MOUSE_RIGHT = 1'b1; else MOUSE_MIDDLE = 1'b1;
    tick();
    MOUSE_RIGHT = 1'b0; MOUSE_MIDDLE = 1'b0;
    tick();
  endtask

  task automatic toggle_game;
    game_active = 1'b0;
    tick(); tick();
    game_active = 1'b1;
    tick(); tick();
  endtask

  initial begin
    repeat (3) tick();
    check_val(1, {29'd0, wr_en, rec_ack, reject}, 32'd0);
    check_val(2, 32'(pen_data), 32'd0);
    check_val(3, 32'(move_count), 32'd0);
    reset = 1'b0;
    tick();

    // request while locked: acked and refused, digit still becomes the pen
    exp_out(10, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    rec(4'd2, 4'd3, 4'd7);
    drain(10);
    check_val(11, 32'(pen_data), 32'd7);

    game_active = 1'b1;
    tick(); tick();
    check_val(12, 32'(move_count), 32'd0);

    exp_out(20, 1'b1, 4'd2, 4'd3, 4'd7, 1'b1, 1'b0);
    rec(4'd2, 4'd3, 4'd7);
    drain(20);
    check_val(21, 32'(move_count), 32'd1);

    exp_out(30, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    rec(4'd0, 4'd0, 4'd5);
    drain(30);
    check_val(31, 32'(pen_data), 32'd5);

    exp_out(40, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    rec(4'd9, 4'd0, 4'd3);
    exp_out(41, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    rec(4'd3, 4'd3, 4'd0);
    drain(41);
    check_val(42, 32'(pen_data), 32'd3);

    exp_out(50, 1'b1, 4'd4, 4'd4, 4'd4, 1'b1, 1'b0);
    rec(4'd4, 4'd4, 4'd4);
    drain(50);
    check_val(51, 32'(pen_data), 32'd4);

    // right release over (8,8), middle release one cycle later
    exp_out(60, 1'b1, 4'd8, 4'd8, 4'd4, 1'b0, 1'b0);
    exp_out(61, 1'b1, 4'd8, 4'd8, 4'd0, 1'b0, 1'b0);
    mouse_row = 4'd8; mouse_col = 4'd8;
    MOUSE_RIGHT = 1'b1; MOUSE_MIDDLE = 1'b1;
    tick();
    MOUSE_RIGHT = 1'b0;
    tick();
    MOUSE_MIDDLE = 1'b0;
    drain(61);
    check_val(62, 32'(move_count), 32'd4);

    // rec and a middle release in the same cycle: rec first, clear next
    exp_out(70, 1'b1, 4'd5, 4'd5, 4'd6, 1'b1, 1'b0);
    exp_out(71, 1'b1, 4'd6, 4'd6, 4'd0, 1'b0, 1'b0);
    mouse_row = 4'd6; mouse_col = 4'd6;
    MOUSE_MIDDLE = 1'b1;
    tick();
    MOUSE_MIDDLE = 1'b0;
    rec_row = 4'd5; rec_col = 4'd5; rec_data = 4'd6; rec_req = 1'b1;
    tick();
    check_val(72, 32'(rec_ack), 32'd1);
    rec_req = 1'b0;
    drain(71);
    check_val(73, 32'(move_count), 32'd6);

    exp_out(80, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    release_btn(1'b0, 4'd3, 4'd15);
    drain(80);
    exp_out(81, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    release_btn(1'b1, 4'd0, 4'd0);
    drain(81);
    check_val(82, 32'(move_count), 32'd6);

`ifdef SUDOKU_MOVE_UNDO_EN
    toggle_game();
    check_val(90, 32'(move_count), 32'd0);
    exp_out(91, 1'b1, 4'd1, 4'd1, 4'd7, 1'b1, 1'b0);
    rec(4'd1, 4'd1, 4'd7);
    exp_out(92, 1'b1, 4'd1, 4'd1, 4'd9, 1'b1, 1'b0);
    rec(4'd1, 4'd1, 4'd9);
    drain(92);
    exp_out(93, 1'b1, 4'd1, 4'd1, 4'd7, 1'b0, 1'b0);
    exp_out(94, 1'b1, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    exp_out(95, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      undo_req = 1'b1;
      tick();
      undo_req = 1'b0;
      tick();
    end
    drain(95);
    check_val(96, 32'(move_count), 32'd2);

    for (int k = 0; k < UNDO_DEPTH + 2; k++) begin
      exp_out(100 + k, 1'b1, 4'd7, 4'd7, 4'((k % 9) + 1), 1'b1, 1'b0);
      rec(4'd7, 4'd7, 4'((k % 9) + 1));
    end
    drain(120);
    check_val(121, 32'(move_count), 32'(UNDO_DEPTH + 4));
    toggle_game();
    check_val(122, 32'(move_count), 32'd0);
    exp_out(123, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    undo_req = 1'b1;
    tick();
    undo_req = 1'b0;
    drain(123);
`else
    // undo is not built: a pulse must leave no trace
    undo_req = 1'b1;
    tick();
    undo_req = 1'b0;
    repeat (3) tick();
    check_val(90, 32'(move_count), 32'd6);
    drain(91);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
